// File: rtl/entropy_collector512.sv
// entropy_collector512
//   Collects 512 accepted raw entropy bits into a block. It presents the block
//   to a SHA-256 wrapper and holds it until the digest is reported complete.
//   FSM states: IDLE -> COLLECT -> HASH -> RELEASE -> (COLLECT | IDLE).
//
// Optional feature: define HEALTH_TEST_EN to enable the repetition-count
//   health test. Without it, health_fail is tied low and no run counter exists.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   enable       level; permits block collection
//   raw_bit      raw entropy bit
//   raw_valid    raw_bit qualifier
//   sha_go       level go to SHA wrapper, held until sha_done
//   sha_data     collected 512-bit block, stable while sha_go=1
//   sha_done     digest complete (only honoured in HASH)
//   busy         state != IDLE (registered)
//   blk_cnt      blocks hashed, wraps
//   health_fail  sticky repetition-count failure
module entropy_collector512 #(
  parameter int unsigned REP_LIMIT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         raw_bit,
  input  logic         raw_valid,
  output logic         sha_go,
  output logic [511:0] sha_data,
  input  logic         sha_done,
  output logic         busy,
  output logic [15:0]  blk_cnt,
  output logic         health_fail
);

  if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_rep_limit
    $error("entropy_collector512: REP_LIMIT must be within 2..255");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, HASH, RELEASE} state_e;

  state_e       state_q, state_d;
  logic [9:0]   bit_cnt_q, bit_cnt_d;
  logic [511:0] data_q, data_d;
  logic [15:0]  blk_q, blk_d;
  logic         go_q, go_d;
  logic         busy_q, busy_d;
  logic         accept;
  logic         trip;

  // Bits are only taken while collecting and still enabled; a falling enable
  // wins over a coincident valid bit.
  assign accept = (state_q == COLLECT) && enable && raw_valid;

`ifdef HEALTH_TEST_EN
  localparam logic [7:0] REP_LIM8 = 8'(REP_LIMIT);

  logic [7:0] run_q, run_d;
  logic       last_q, last_d;
  logic       hf_q, hf_d;

  // run_q == 0 means "no bit seen yet in this collection run", so the first
  // accepted bit always starts a fresh run of length 1.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    hf_d   = hf_q;
    trip   = 1'b0;
    if (state_q != COLLECT) begin
      run_d  = '0;
      last_d = 1'b0;
    end else if (accept) begin
      last_d = raw_bit;
      if (run_q == 8'd0 || raw_bit != last_q) run_d = 8'd1;
      else                                    run_d = run_q + 8'd1;
      // A trip restarts the run so a further REP_LIMIT repeats trip again.
      if (run_d >= REP_LIM8) begin
        trip  = 1'b1;
        hf_d  = 1'b1;
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q  <= '0;
      last_q <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
      hf_q   <= hf_d;
    end
  end

  assign health_fail = hf_q;
`else
  assign trip        = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    blk_d     = blk_q;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (enable) state_d = COLLECT;
      end
      COLLECT: begin
        if (!enable) begin
          // Partial block is abandoned; data stays but is never presented.
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (accept) begin
          data_d = {data_q[510:0], raw_bit};
          if (trip) begin
            bit_cnt_d = '0;
          end else if (bit_cnt_q == 10'd511) begin
            bit_cnt_d = '0;
            state_d   = HASH;
          end else begin
            bit_cnt_d = bit_cnt_q + 10'd1;
          end
        end
      end
      HASH: begin
        // enable is deliberately ignored here: a started hash always finishes.
        if (sha_done) begin
          blk_d   = blk_q + 16'd1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        bit_cnt_d = '0;
        state_d   = enable ? COLLECT : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered alongside the state they describe.
    go_d   = (state_d == HASH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      blk_q     <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      blk_q     <= blk_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
    end
  end

  assign sha_go   = go_q;
  assign sha_data = data_q;
  assign busy     = busy_q;
  assign blk_cnt  = blk_q;

endmodule

// File: tb/tb_entropy_collector512.sv
// Testbench for entropy_collector512: directed table, multi-cycle sequences,
// and randomized traffic against a behavioural model kept here.
module tb_entropy_collector512;
  localparam int REP = 32;
  localparam logic [511:0] PAT_A = {128{4'hA}};
`ifdef HEALTH_TEST_EN
  localparam bit HT = 1'b1;
`else
  localparam bit HT = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic         raw_bit = 1'b0, raw_valid = 1'b0, sha_done = 1'b0;
  logic         sha_go, busy, health_fail;
  logic [511:0] sha_data;
  logic [15:0]  blk_cnt;

  always #5 clk = ~clk;

  entropy_collector512 #(.REP_LIMIT(REP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .raw_bit(raw_bit),
    .raw_valid(raw_valid), .sha_go(sha_go), .sha_data(sha_data),
    .sha_done(sha_done), .busy(busy), .blk_cnt(blk_cnt),
    .health_fail(health_fail)
  );

  int n_tests = 0, n_fail = 0;

  // Behavioural model: phase 0 idle, 1 collecting, 2 hashing, 3 release.
  // m_hist holds the most recent accepted bits (oldest first).
  int m_phase = 0, m_cnt = 0, m_blk = 0, m_run = 0;
  bit m_hf = 0, m_last = 0;
  bit m_hist[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] m_data();
    logic [511:0] d = '0;
    for (int i = 0; i < m_hist.size(); i++) d[m_hist.size()-1-i] = m_hist[i];
    return d;
  endfunction

  task automatic model_step(input logic r, input logic en, input logic vld,
                            input logic b, input logic done);
    if (!r) begin
      m_phase = 0; m_cnt = 0; m_blk = 0; m_run = 0; m_hf = 0; m_last = 0;
      m_hist.delete();
    end else begin
      case (m_phase)
        0: if (en) begin m_phase = 1; m_cnt = 0; m_run = 0; end
        1: begin
          if (!en) begin
            m_phase = 0; m_cnt = 0;
          end else if (vld) begin
            m_hist.push_back(b);
            if (m_hist.size() > 512) void'(m_hist.pop_front());
            m_run  = (m_run == 0 || b != m_last) ? 1 : m_run + 1;
            m_last = b;
            if (HT && m_run >= REP) begin
              m_hf = 1; m_cnt = 0; m_run = 0;
            end else begin
              m_cnt++;
              if (m_cnt == 512) begin m_phase = 2; m_cnt = 0; end
            end
          end
        end
        2: if (done) begin m_blk = (m_blk + 1) % 65536; m_phase = 3; end
        default: begin m_phase = en ? 1 : 0; m_cnt = 0; m_run = 0; end
      endcase
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare 1 time unit later.
  task automatic drive(input logic r, input logic en, input logic vld,
                       input logic b, input logic done);
    rst = r; enable = en; raw_valid = vld; raw_bit = b; sha_done = done;
    @(posedge clk);
    model_step(r, en, vld, b, done);
    #1;
    chk("m_go",   32'(sha_go),      32'(m_phase == 2));
    chk("m_busy", 32'(busy),        32'(m_phase != 0));
    chk("m_blk",  32'(blk_cnt),     32'(m_blk));
    chk("m_hf",   32'(health_fail), 32'(m_hf));
    if (m_phase == 2 || !r) chk_data("m_data", sha_data, m_data());
  endtask

  typedef struct {
    logic r, en, vld, b, done;
    logic exp_busy, exp_go;
    logic [15:0] exp_blk;
  } vec_t;

  vec_t tbl[9];
  logic [511:0] snap;
  logic en_r;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].r, tbl[i].en, tbl[i].vld, tbl[i].b, tbl[i].done);
      chk("tbl_busy", 32'(busy),    32'(tbl[i].exp_busy));
      chk("tbl_go",   32'(sha_go),  32'(tbl[i].exp_go));
      chk("tbl_blk",  32'(blk_cnt), 32'(tbl[i].exp_blk));
    end

    // Full alternating block starting with 1.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_data("rst_data", sha_data, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i % 2 == 0), 1'b0);
      if (i == 510) chk("go_before_512", 32'(sha_go), 32'd0);
    end
    chk("go_after_512", 32'(sha_go), 32'd1);
    chk_data("data_aaaa", sha_data, PAT_A);

    // Bits offered during HASH are dropped; block stays stable.
    snap = sha_data;
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i % 2 == 1), 1'b0);
      chk_data("hash_hold", sha_data, snap);
      chk("hash_go", 32'(sha_go), 32'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);   // done with a coincident bit
    chk("rel_go",   32'(sha_go),  32'd0);
    chk("rel_busy", 32'(busy),    32'd1);
    chk("rel_blk",  32'(blk_cnt), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("col_busy", 32'(busy),   32'd1);
    chk("col_go",   32'(sha_go), 32'd0);

    // Abort a partial block, then collect a fresh full block.
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 1'b1, (i % 3 == 0), 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i % 3 == 1), 1'b0);
      if (i == 510) chk("rego_before", 32'(sha_go), 32'd0);
    end
    chk("rego_after", 32'(sha_go), 32'd1);

    // enable dropped during HASH does not abort.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("noabort_go", 32'(sha_go), 32'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("dis_rel_busy", 32'(busy),    32'd1);
    chk("dis_rel_blk",  32'(blk_cnt), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_idle_busy", 32'(busy),   32'd0);
    chk("dis_idle_go",   32'(sha_go), 32'd0);

    // Repetition-count health test.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b1, (i % 2 == 0), 1'b0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 30) chk("hf_before", 32'(health_fail), 32'd0);
    end
    chk("hf_after", 32'(health_fail), 32'(HT));
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i % 3 == 0), 1'b0);
      if (i == 510) chk("hf_go_511", 32'(sha_go), HT ? 32'd0 : 32'd1);
    end
    chk("hf_go_512", 32'(sha_go), 32'd1);

    // Reset in the middle of a hash that never completes.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) drive(1'b1, 1'b1, 1'b1, (i % 5 < 2), 1'b0);
    chk("pre_rst_go",  32'(sha_go),  32'd1);
    chk("pre_rst_blk", 32'(blk_cnt), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_go",   32'(sha_go),      32'd0);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_blk",  32'(blk_cnt),     32'd0);
    chk("rst_hf",   32'(health_fail), 32'd0);
    chk_data("rst_data2", sha_data, '0);

    // Randomized traffic against the model.
    en_r = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 399) == 0) en_r = ~en_r;
      drive(($urandom_range(0, 2999) != 0), en_r, ($urandom_range(0, 9) < 8),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/entropy_collector512.md
ENTROPY_COLLECTOR512 -- requirements
Module: entropy_collector512

Interface
REQ-001 SHALL have parameter REP_LIMIT, default 32, consecutive identical accepted bits that trip the health test (range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  level; high permits block collection.
REQ-005 SHALL have port raw_bit  input  1  raw entropy bit from ring-oscillator sampler.
REQ-006 SHALL have port raw_valid  input  1  raw_bit qualifier, one bit per asserted cycle.
REQ-007 SHALL have port sha_go  output  1  level go to the SHA-256 wrapper, held high until sha_done.
REQ-008 SHALL have port sha_data  output  512  collected block, stable whenever sha_go=1.
REQ-009 SHALL have port sha_done  input  1  digest-complete from the SHA-256 wrapper.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port blk_cnt  output  16  count of blocks hashed, wraps 0xFFFF->0.
REQ-012 SHALL have port health_fail  output  1  sticky repetition-count failure flag.

Function
REQ-013 SHALL implement states IDLE, COLLECT, HASH, RELEASE.
REQ-014 IDLE->COLLECT SHALL occur on enable=1; bit counter cleared on entry.
REQ-015 In COLLECT, each cycle with raw_valid=1 SHALL accept one bit: sha_data shifts left by 1, raw_bit enters bit 0; first accepted bit ends at bit 511.
REQ-016 A 10-bit bit counter SHALL increment per accepted bit; on the 512th accepted bit the state SHALL move to HASH and sha_go SHALL assert the following cycle.
REQ-017 In HASH, sha_go SHALL be 1, sha_data SHALL not change, raw_valid bits SHALL be dropped.
REQ-018 HASH->RELEASE SHALL occur on the first cycle sha_done=1; blk_cnt SHALL increment by 1 on that same edge.
REQ-019 RELEASE SHALL last exactly one cycle with sha_go=0, then go to COLLECT if enable=1, else IDLE; bit counter cleared.
REQ-020 sha_done outside HASH SHALL be ignored.
REQ-021 enable falling in COLLECT SHALL return to IDLE the next cycle, discarding the partial block (counter cleared, sha_data retained but not presented).
REQ-022 enable falling in HASH SHALL not abort; the hash completes, RELEASE then IDLE.
REQ-023 raw_valid coincident with sha_done in HASH SHALL drop the bit.
REQ-024 raw_valid in IDLE or RELEASE SHALL be dropped.
REQ-025 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-026 rst=0 at a clock edge SHALL force state IDLE, sha_go=0, sha_data=0, bit counter=0, blk_cnt=0, health_fail=0, busy=0, run counter=0.
REQ-027 Reset during HASH SHALL drop sha_go the next cycle; the SHA wrapper shares the reset and SHALL be reset alongside.

Configuration
REQ-028 With macro HEALTH_TEST_EN defined, an 8-bit run counter SHALL track consecutive identical accepted bits (reset to 1 on change, counter and last-bit cleared on entry to COLLECT).
REQ-029 With HEALTH_TEST_EN, reaching REP_LIMIT identical bits SHALL set health_fail (sticky until reset) and discard the current block: bit counter cleared, state remains COLLECT.
REQ-030 Without HEALTH_TEST_EN, health_fail SHALL be tied 0 and no run-counter logic SHALL be present.

Verification
REQ-031 Reset, enable=1, 512 raw_valid cycles of alternating 1/0 starting with 1 -> sha_go=1 one cycle after the 512th bit, sha_data=0xAAAA...AAAA (512 bits).
REQ-032 In HASH, toggle raw_bit with raw_valid=1 for 50 cycles, then sha_done=1 -> sha_data unchanged throughout, blk_cnt=1, sha_go=0 for exactly one cycle, busy stays 1.
REQ-033 Drop enable after 100 accepted bits -> IDLE next cycle, busy=0; re-enable and feed 512 bits -> sha_go after exactly 512 new bits.
REQ-034 Drop enable during HASH, then sha_done -> RELEASE, IDLE, sha_go=0, blk_cnt incremented.
REQ-035 HEALTH_TEST_EN defined, REP_LIMIT=32: feed 10 alternating bits then 32 ones -> health_fail=1 after the 32nd one, block restarts, further 512 varied bits produce sha_go; without macro same stimulus -> health_fail=0.
REQ-036 Assert rst=0 mid-HASH with sha_done never arriving -> all outputs at reset values one cycle later; blk_cnt=0.
